// File: rtl/chk_pkg.sv
// Shared types for the data-memory write checker: FSM states, verdict causes
// and the expected-write entry.
package chk_pkg;

  typedef enum logic [1:0] {
    StRun,
    StPass,
    StFail
  } chk_state_e;

  typedef enum logic [2:0] {
    CauseNone       = 3'd0,
    CauseAddr       = 3'd1,
    CauseData       = 3'd2,
    CauseUnexpected = 3'd3,
    CauseMissing    = 3'd4,
    CauseTimeout    = 3'd5
  } chk_cause_e;

  localparam int unsigned ChkAw = 32;
  localparam int unsigned ChkDw = 32;

  // Default-width entry; the top builds its own entry type from AW/DW.
  typedef struct packed {
    logic [ChkAw-1:0] adr;
    logic [ChkDw-1:0] data;
  } exp_entry_t;

endpackage

// File: rtl/mem_write_checker_if.sv
// Bundle of the expected-write feed, the observed write port and the verdict
// outputs of mem_write_checker.
interface mem_write_checker_if #(
  parameter int unsigned AW = 32,
  parameter int unsigned DW = 32,
  parameter int unsigned CW = 16
);

  logic                     exp_valid;
  logic                     exp_ready;
  logic [AW-1:0]            exp_adr;
  logic [DW-1:0]            exp_data;
  logic                     memwrite;
  logic [AW-1:0]            adr;
  logic [DW-1:0]            writedata;
  logic                     done;
  logic                     pass;
  chk_pkg::chk_cause_e      fail_cause;
  logic [CW-1:0]            write_count;
  logic [AW-1:0]            fail_adr;

  modport master (
    output exp_valid, exp_adr, exp_data, memwrite, adr, writedata,
    input  exp_ready, done, pass, fail_cause, write_count, fail_adr
  );

  modport slave (
    input  exp_valid, exp_adr, exp_data, memwrite, adr, writedata,
    output exp_ready, done, pass, fail_cause, write_count, fail_adr
  );

endinterface

// File: rtl/chk_fifo.sv
// Show-ahead FIFO of expected writes; pointers carry a wrap bit so that full
// and empty fall out of a plain pointer comparison.
module chk_fifo
  import chk_pkg::*;
#(
  parameter int unsigned DEPTH   = 8,
  parameter type         entry_t = exp_entry_t
) (
  input  logic   clk,
  input  logic   reset,
  input  logic   push,
  input  logic   pop,
  input  entry_t wentry,
  output logic   full,
  output logic   empty,
  output entry_t head
);

  localparam int unsigned PW = $clog2(DEPTH);

  logic [PW:0] wr_q;
  logic [PW:0] rd_q;
  entry_t      mem_q [DEPTH];

  assign empty = (wr_q == rd_q);
  assign full  = (wr_q[PW] != rd_q[PW]) && (wr_q[PW-1:0] == rd_q[PW-1:0]);
  assign head  = mem_q[rd_q[PW-1:0]];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      if (push) wr_q <= wr_q + 1'b1;
      if (pop && !empty) rd_q <= rd_q + 1'b1;
    end
  end

  // A push while full only arrives together with a pop, so it overwrites the
  // slot whose head is leaving this cycle.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_q[PW-1:0]] <= wentry;
  end

endmodule

// File: rtl/mem_write_checker.sv
// Monitors the data-memory write port against an in-order queue of expected
// writes and latches a sticky pass/fail verdict.
module mem_write_checker
  import chk_pkg::*;
#(
  parameter int unsigned   AW         = 32,
  parameter int unsigned   DW         = 32,
  parameter int unsigned   DEPTH      = 8,
  parameter logic [AW-1:0] DONE_ADR   = 84,
  parameter logic [DW-1:0] DONE_DATA  = 7,
  parameter bit            CHECK_DATA = 1'b1,
  parameter int unsigned   TIMEOUT    = 1024,
  parameter int unsigned   CW         = 16
) (
  input logic                clk,
  input logic                reset,
  mem_write_checker_if.slave bus
);

  typedef struct packed {
    logic [AW-1:0] adr;
    logic [DW-1:0] data;
  } entry_t;

  localparam int unsigned TW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  chk_state_e    state_q, state_d;
  chk_cause_e    cause_q, cause_d;
  logic [CW-1:0] count_q, count_d;
  logic [AW-1:0] fail_adr_q, fail_adr_d;
  logic [TW-1:0] timer_q, timer_d;

  logic   run;
  logic   full;
  logic   empty;
  logic   push;
  logic   pop;
  entry_t head;
  entry_t wentry;

  assign run           = (state_q == StRun);
  assign bus.exp_ready = run && !full;
  // A matching write frees the head slot, so a full queue may still take a push.
  assign push          = bus.exp_valid && run && (!full || pop);
  assign wentry        = '{adr: bus.exp_adr, data: bus.exp_data};

  chk_fifo #(
    .DEPTH   (DEPTH),
    .entry_t (entry_t)
  ) u_fifo (
    .clk    (clk),
    .reset  (reset),
    .push   (push),
    .pop    (pop),
    .wentry (wentry),
    .full   (full),
    .empty  (empty),
    .head   (head)
  );

  always_comb begin
    state_d    = state_q;
    cause_d    = cause_q;
    count_d    = count_q;
    fail_adr_d = fail_adr_q;
    timer_d    = timer_q;
    pop        = 1'b0;
    if (run) begin
      if (bus.memwrite) begin
        if (bus.adr == DONE_ADR) begin
          if (!empty) begin
            state_d    = StFail;
            cause_d    = CauseMissing;
            fail_adr_d = bus.adr;
          end else if (CHECK_DATA && (bus.writedata != DONE_DATA)) begin
            state_d    = StFail;
            cause_d    = CauseData;
            fail_adr_d = bus.adr;
          end else begin
            state_d = StPass;
          end
        end else if (empty) begin
          state_d    = StFail;
          cause_d    = CauseUnexpected;
          fail_adr_d = bus.adr;
        end else if (bus.adr != head.adr) begin
          state_d    = StFail;
          cause_d    = CauseAddr;
          fail_adr_d = bus.adr;
        end else if (CHECK_DATA && (bus.writedata != head.data)) begin
          state_d    = StFail;
          cause_d    = CauseData;
          fail_adr_d = bus.adr;
        end else begin
          pop     = 1'b1;
          timer_d = '0;
          if (count_q != '1) count_d = count_q + 1'b1;
        end
      end else if ((TIMEOUT != 0) && ((32'(timer_q) + 32'd1) >= TIMEOUT)) begin
        state_d    = StFail;
        cause_d    = CauseTimeout;
        fail_adr_d = '0;
      end else begin
        timer_d = timer_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= StRun;
      cause_q    <= CauseNone;
      count_q    <= '0;
      fail_adr_q <= '0;
      timer_q    <= '0;
    end else begin
      state_q    <= state_d;
      cause_q    <= cause_d;
      count_q    <= count_d;
      fail_adr_q <= fail_adr_d;
      timer_q    <= timer_d;
    end
  end

  assign bus.done        = (state_q != StRun);
  assign bus.pass        = (state_q == StPass);
  assign bus.fail_cause  = cause_q;
  assign bus.write_count = count_q;
  assign bus.fail_adr    = fail_adr_q;

endmodule

// File: tb/tb_mem_write_checker.sv
// Drives two checkers (data compare with timeout 20, address-only without timeout)
// from one stimulus stream and compares both against a queue-based model.
module tb_mem_write_checker;
  import chk_pkg::*;

  localparam int unsigned Depth = 8;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  mem_write_checker_if #(.AW(32), .DW(32), .CW(16)) bus0 ();
  mem_write_checker_if #(.AW(32), .DW(32), .CW(16)) bus1 ();

  mem_write_checker #(
    .AW(32), .DW(32), .DEPTH(8), .DONE_ADR(32'd84), .DONE_DATA(32'd7),
    .CHECK_DATA(1'b1), .TIMEOUT(20), .CW(16)
  ) dut0 (.clk(clk), .reset(reset_n), .bus(bus0.slave));

  mem_write_checker #(
    .AW(32), .DW(32), .DEPTH(8), .DONE_ADR(32'd84), .DONE_DATA(32'd7),
    .CHECK_DATA(1'b0), .TIMEOUT(0), .CW(16)
  ) dut1 (.clk(clk), .reset(reset_n), .bus(bus1.slave));

  typedef struct {
    logic [31:0] adr;
    logic [31:0] data;
  } ent_t;

  ent_t        mq [2][$];
  bit          m_done [2];
  bit          m_pass [2];
  logic [2:0]  m_cause [2];
  int unsigned m_count [2];
  int unsigned m_timer [2];
  logic [31:0] m_fadr [2];
  bit          chk_data [2] = '{1'b1, 1'b0};
  int unsigned tmo [2] = '{20, 0};

  int vectors = 0;
  int miscompares = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    for (int k = 0; k < 2; k++) begin
      mq[k].delete();
      m_done[k] = 0; m_pass[k] = 0; m_cause[k] = 3'd0;
      m_count[k] = 0; m_timer[k] = 0; m_fadr[k] = 0;
    end
  endtask

  task automatic model_fail(input int k, input logic [2:0] c, input logic [31:0] a);
    m_done[k] = 1; m_pass[k] = 0; m_cause[k] = c; m_fadr[k] = a;
  endtask

  task automatic model_edge(input int k, input bit ev, input logic [31:0] ea,
                            input logic [31:0] ed, input bit mw, input logic [31:0] a,
                            input logic [31:0] wd);
    bit   popped;
    int   pre;
    ent_t e;
    if (m_done[k]) return;
    popped = 0;
    pre = mq[k].size();
    if (mw) begin
      if (a == 32'd84) begin
        if (pre != 0) model_fail(k, CauseMissing, a);
        else if (chk_data[k] && wd != 32'd7) model_fail(k, CauseData, a);
        else begin m_done[k] = 1; m_pass[k] = 1; end
      end else if (pre == 0) model_fail(k, CauseUnexpected, a);
      else if (a != mq[k][0].adr) model_fail(k, CauseAddr, a);
      else if (chk_data[k] && wd != mq[k][0].data) model_fail(k, CauseData, a);
      else begin
        mq[k].delete(0);
        popped = 1;
        if (m_count[k] < 65535) m_count[k]++;
        m_timer[k] = 0;
      end
    end else begin
      m_timer[k]++;
      if (tmo[k] != 0 && m_timer[k] >= tmo[k]) model_fail(k, CauseTimeout, 32'd0);
    end
    if (ev && (pre < Depth || popped)) begin
      e.adr = ea; e.data = ed;
      mq[k].push_back(e);
    end
  endtask

  task automatic cmp_out(input int k);
    logic [31:0] o_done, o_pass, o_cause, o_count, o_fadr;
    string p;
    p = (k == 0) ? "dut0" : "dut1";
    if (k == 0) begin
      o_done = 32'(bus0.done); o_pass = 32'(bus0.pass); o_cause = 32'(bus0.fail_cause);
      o_count = 32'(bus0.write_count); o_fadr = bus0.fail_adr;
    end else begin
      o_done = 32'(bus1.done); o_pass = 32'(bus1.pass); o_cause = 32'(bus1.fail_cause);
      o_count = 32'(bus1.write_count); o_fadr = bus1.fail_adr;
    end
    check({p, "_done"}, o_done, 32'(m_done[k]));
    check({p, "_pass"}, o_pass, 32'(m_pass[k]));
    check({p, "_cause"}, o_cause, 32'(m_cause[k]));
    check({p, "_count"}, o_count, m_count[k]);
    check({p, "_fail_adr"}, o_fadr, m_fadr[k]);
  endtask

  task automatic drive(input bit ev, input logic [31:0] ea, input logic [31:0] ed,
                       input bit mw, input logic [31:0] a, input logic [31:0] wd);
    bus0.exp_valid = ev; bus0.exp_adr = ea; bus0.exp_data = ed;
    bus0.memwrite = mw;  bus0.adr = a;      bus0.writedata = wd;
    bus1.exp_valid = ev; bus1.exp_adr = ea; bus1.exp_data = ed;
    bus1.memwrite = mw;  bus1.adr = a;      bus1.writedata = wd;
  endtask

  // One clock: drive, check readiness, clock, advance the model, check outputs.
  task automatic step(input bit ev, input logic [31:0] ea, input logic [31:0] ed,
                      input bit mw, input logic [31:0] a, input logic [31:0] wd);
    drive(ev, ea, ed, mw, a, wd);
    #1;
    check("dut0_exp_ready", 32'(bus0.exp_ready), 32'(!m_done[0] && mq[0].size() < Depth));
    check("dut1_exp_ready", 32'(bus1.exp_ready), 32'(!m_done[1] && mq[1].size() < Depth));
    @(posedge clk);
    model_edge(0, ev, ea, ed, mw, a, wd);
    model_edge(1, ev, ea, ed, mw, a, wd);
    #1;
    cmp_out(0);
    cmp_out(1);
  endtask

  task automatic do_reset();
    drive(0, 0, 0, 0, 0, 0);
    reset_n = 1'b0;
    model_clear();
    #2;
    cmp_out(0);
    cmp_out(1);
    check("rst_exp_ready0", 32'(bus0.exp_ready), 32'd1);
    check("rst_exp_ready1", 32'(bus1.exp_ready), 32'd1);
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic push_only(input logic [31:0] ea, input logic [31:0] ed);
    step(1, ea, ed, 0, 0, 0);
  endtask

  task automatic write_only(input logic [31:0] a, input logic [31:0] wd);
    step(0, 0, 0, 1, a, wd);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired before summary");
    $fatal(1);
  end

  initial begin
    logic [31:0] ea, ed, a, wd;
    bit ev, mw;
    int r;

    drive(0, 0, 0, 0, 0, 0);
    #3;
    do_reset();

    // Match then terminal write.
    push_only(80, 7);
    write_only(80, 7);
    write_only(84, 7);
    check("t1_pass", 32'(bus0.pass), 32'd1);
    check("t1_done", 32'(bus0.done), 32'd1);
    check("t1_count", 32'(bus0.write_count), 32'd1);
    check("t1_cause", 32'(bus0.fail_cause), 32'(CauseNone));

    // Address mismatch is sticky.
    do_reset();
    push_only(80, 7);
    write_only(76, 7);
    check("t2_cause", 32'(bus0.fail_cause), 32'(CauseAddr));
    check("t2_fail_adr", bus0.fail_adr, 32'd76);
    write_only(84, 7);
    check("t2_still_no_pass", 32'(bus0.pass), 32'd0);

    // Data mismatch: dut0 fails, dut1 ignores data.
    do_reset();
    push_only(80, 7);
    write_only(80, 9);
    check("t3_cause_data", 32'(bus0.fail_cause), 32'(CauseData));
    check("t3_nodata_count", 32'(bus1.write_count), 32'd1);
    write_only(84, 7);
    check("t3_nodata_pass", 32'(bus1.pass), 32'd1);

    // Fill, drop a push while full, then push+pop while full.
    do_reset();
    for (int i = 0; i < 8; i++) push_only(32'(i * 4), 32'(i));
    check("t4_full_ready", 32'(bus0.exp_ready), 32'd0);
    push_only(100, 1);
    step(1, 200, 55, 1, 0, 0);
    check("t4_still_full", 32'(bus0.exp_ready), 32'd0);
    for (int i = 1; i < 8; i++) write_only(32'(i * 4), 32'(i));
    write_only(200, 55);
    check("t4_count", 32'(bus0.write_count), 32'd9);
    write_only(84, 7);
    check("t4_pass", 32'(bus0.pass), 32'd1);

    // Unexpected and missing.
    do_reset();
    step(1, 80, 7, 1, 80, 7);
    check("t5_unexpected", 32'(bus0.fail_cause), 32'(CauseUnexpected));
    do_reset();
    push_only(80, 7);
    write_only(84, 7);
    check("t5_missing", 32'(bus0.fail_cause), 32'(CauseMissing));

    // Timeout on the 20th idle edge.
    do_reset();
    for (int i = 0; i < 19; i++) step(0, 0, 0, 0, 0, 0);
    check("t6_not_yet", 32'(bus0.done), 32'd0);
    step(0, 0, 0, 0, 0, 0);
    check("t6_timeout", 32'(bus0.fail_cause), 32'(CauseTimeout));
    check("t6_fail_adr", bus0.fail_adr, 32'd0);

    // Reset pulse in the middle of a run.
    do_reset();
    push_only(8, 3);
    push_only(12, 4);
    write_only(8, 3);
    do_reset();

    // Randomized runs.
    for (int run = 0; run < 6; run++) begin
      do_reset();
      for (int i = 0; i < 40; i++) begin
        ev = ($urandom_range(0, 2) != 0);
        ea = 32'($urandom_range(0, 20)) * 4;
        if (ea == 32'd84) ea = 32'd88;
        ed = 32'($urandom_range(0, 15));
        mw = 0; a = 0; wd = 0;
        if (mq[0].size() > 0 && $urandom_range(0, 2) != 0) begin
          mw = 1; a = mq[0][0].adr; wd = mq[0][0].data;
          r = $urandom_range(0, 24);
          if (r == 0) a = a + 32'd128;
          else if (r == 1) wd = wd ^ 32'd1;
        end else if ($urandom_range(0, 49) == 0) begin
          mw = 1; a = $urandom; wd = $urandom;
        end
        step(ev, ea, ed, mw, a, wd);
      end
      while (mq[0].size() > 0 && !m_done[0]) write_only(mq[0][0].adr, mq[0][0].data);
      write_only(84, 7);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
